exc_controller: RTL

EXC_CONTROLLER -- requirements
Module: exc_controller

---
 rtl/exc_controller.sv | 129 ++++++++++++
 1 files changed

// File: rtl/exc_controller.sv
// Exception request controller: captures external IRQ and invalid-opcode
// events into pending bits, then requests them one at a time from the
// datapath with fixed priority. The datapath acknowledges each request,
// services it in a handler, and ends the handler with ERET.
//
// Optional build macro: EXC_COUNT_EN adds a saturating 16-bit count of
// acknowledged exceptions on output exc_count.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | nothing being serviced; picks the highest-priority pending
// REQ     | Exc=1 with EStatus held until the datapath acknowledges
// HANDLER | exception being serviced; events are only latched
module exc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_irq,
  input  logic        irq_en,
  input  logic        bad_opcode,
  input  logic        ERet,
  input  logic        ExcAck,
  output logic        Exc,
  output logic [3:0]  EStatus,
  output logic        in_handler
`ifdef EXC_COUNT_EN
  ,
  output logic [15:0] exc_count
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    HANDLER = 2'b10
  } state_e;

  localparam logic [3:0] CAUSE_NONE = 4'b0000;
  localparam logic [3:0] CAUSE_IRQ  = 4'b0001;
  localparam logic [3:0] CAUSE_OP   = 4'b0010;

  state_e     state_q;
  logic       exc_q;
  logic [3:0] estatus_q;
  logic       in_handler_q;
  logic       irq_pend_q, irq_pend_d;
  logic       op_pend_q,  op_pend_d;
  logic       ack_fire;

  // Acknowledge only counts in REQ; a fresh event in the same cycle as
  // the clear keeps its pending bit set.
  always_comb begin
    ack_fire   = (state_q == REQ) && ExcAck;
    op_pend_d  = bad_opcode |
                 (op_pend_q & ~(ack_fire && (estatus_q == CAUSE_OP)));
    irq_pend_d = (ext_irq & irq_en) |
                 (irq_pend_q & ~(ack_fire && (estatus_q == CAUSE_IRQ)));
  end

  // Pending event capture, active in every state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_pend_q  <= 1'b0;
      irq_pend_q <= 1'b0;
    end else begin
      op_pend_q  <= op_pend_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  // Request sequencing FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      exc_q        <= 1'b0;
      estatus_q    <= CAUSE_NONE;
      in_handler_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op_pend_q || irq_pend_q) begin
            state_q   <= REQ;
            exc_q     <= 1'b1;
            estatus_q <= op_pend_q ? CAUSE_OP : CAUSE_IRQ;
          end
        end
        REQ: begin
          if (ExcAck) begin
            state_q      <= HANDLER;
            exc_q        <= 1'b0;
            in_handler_q <= 1'b1;
          end
        end
        HANDLER: begin
          if (ERet) begin
            state_q      <= IDLE;
            in_handler_q <= 1'b0;
            estatus_q    <= CAUSE_NONE;
          end
        end
        default: begin
          state_q      <= IDLE;
          exc_q        <= 1'b0;
          in_handler_q <= 1'b0;
          estatus_q    <= CAUSE_NONE;
        end
      endcase
    end
  end

  assign Exc        = exc_q;
  assign EStatus    = estatus_q;
  assign in_handler = in_handler_q;

`ifdef EXC_COUNT_EN
  logic [15:0] exc_count_q;

  // Saturating count of acknowledged exceptions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exc_count_q <= 16'h0000;
    end else if (ack_fire && (exc_count_q != 16'hFFFF)) begin
      exc_count_q <= exc_count_q + 16'h0001;
    end
  end

  assign exc_count = exc_count_q;
`endif

endmodule
